// File: rtl/nbit_cmp_pkg.sv
// Shared types for the magnitude comparator tree: per-node {gt, eq} result
// and {gt, lt, eq} flag encodings for scoreboards.
package nbit_cmp_pkg;

  typedef struct packed {
    logic gt;
    logic eq;
  } cmp_result_t;

  // Flag encodings ordered {gt, lt, eq}, matching the top-level output order.
  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

endpackage

// File: rtl/nbit_cmp_merge.sv
// MSB-first merge of two comparison sub-results into one.
// Combinational, zero latency, no backpressure.
module nbit_cmp_merge
  import nbit_cmp_pkg::*;
(
  input  cmp_result_t hi,
  input  cmp_result_t lo,
  output cmp_result_t res
);

  // The high half decides unless it is equal, then the low half decides.
  assign res.gt = hi.gt | (hi.eq & lo.gt);
  assign res.eq = hi.eq & lo.eq;

endmodule

// File: rtl/nbit_comparator.sv
// Registered N-bit signed/unsigned magnitude comparator with one-hot gt/lt/eq flags.
// Latency 1 cycle, accepts a sample every cycle, no backpressure.
module nbit_comparator
  import nbit_cmp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         cmp_signed,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  output logic         A_gt_B,
  output logic         A_lt_B,
  output logic         A_eq_B
);

  localparam int D = $clog2(N);
  localparam int L = 1 << D;

  // Heap-ordered tree: node 0 is the root, children of i are 2i+1 (high) and
  // 2i+2 (low); leaves sit at L-1.., leftmost leaf holding the MSB.
  cmp_result_t node [2*L-1];

  for (genvar j = 0; j < L; j++) begin : g_leaf
    if (j == 0) begin : g_msb
      // Signed mode inverts the MSB sense: a 0 MSB means the larger value.
      assign node[L-1+j].gt = cmp_signed ? (~A[N-1] & B[N-1]) : (A[N-1] & ~B[N-1]);
      assign node[L-1+j].eq = ~(A[N-1] ^ B[N-1]);
    end else if (j < N) begin : g_bit
      assign node[L-1+j].gt = A[N-1-j] & ~B[N-1-j];
      assign node[L-1+j].eq = ~(A[N-1-j] ^ B[N-1-j]);
    end else begin : g_pad
      assign node[L-1+j].gt = 1'b0;
      assign node[L-1+j].eq = 1'b1;
    end
  end

  for (genvar i = 0; i < L-1; i++) begin : g_node
    nbit_cmp_merge u_merge (
      .hi  (node[2*i+1]),
      .lo  (node[2*i+2]),
      .res (node[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      A_gt_B    <= 1'b0;
      A_lt_B    <= 1'b0;
      A_eq_B    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        A_gt_B <= node[0].gt;
        A_lt_B <= ~node[0].gt & ~node[0].eq;
        A_eq_B <= node[0].eq;
      end
    end
  end

endmodule

// File: tb/tb_nbit_comparator.sv
// Directed and sweep bench for nbit_comparator at N=4, N=7 and N=1.
module tb_nbit_comparator;
  import nbit_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic       v4, s4;
  logic [3:0] a4, b4;
  logic       ov4, gt4, lt4, eq4;

  logic       v7, s7;
  logic [6:0] a7, b7;
  logic       ov7, gt7, lt7, eq7;

  logic       v1, s1;
  logic [0:0] a1, b1;
  logic       ov1, gt1, lt1, eq1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nbit_comparator #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .cmp_signed(s4), .A(a4), .B(b4),
    .out_valid(ov4), .A_gt_B(gt4), .A_lt_B(lt4), .A_eq_B(eq4)
  );

  nbit_comparator #(.N(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(v7), .cmp_signed(s7), .A(a7), .B(b7),
    .out_valid(ov7), .A_gt_B(gt7), .A_lt_B(lt7), .A_eq_B(eq7)
  );

  nbit_comparator #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .cmp_signed(s1), .A(a1), .B(b1),
    .out_valid(ov1), .A_gt_B(gt1), .A_lt_B(lt1), .A_eq_B(eq1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_cmp(input int a, input int b, input int n, input bit sgn);
    int sa = a;
    int sb = b;
    if (sgn && a >= (1 << (n-1))) sa = a - (1 << n);
    if (sgn && b >= (1 << (n-1))) sb = b - (1 << n);
    if (sa > sb) return CMP_GT;
    if (sa < sb) return CMP_LT;
    return CMP_EQ;
  endfunction

  task automatic drive4(input bit sgn, input logic [3:0] a, input logic [3:0] b);
    v4 = 1'b1; s4 = sgn; a4 = a; b4 = b;
  endtask

  // Directed vectors: {A, B, expected flags}
  logic [3:0] u_a [5] = '{4'b0101, 4'b0110, 4'b0010, 4'b1111, 4'b0000};
  logic [3:0] u_b [5] = '{4'b0101, 4'b0011, 4'b0111, 4'b0000, 4'b1111};
  logic [2:0] u_e [5] = '{CMP_EQ, CMP_GT, CMP_LT, CMP_GT, CMP_LT};
  logic [3:0] s_a [5] = '{4'b1111, 4'b0000, 4'b1000, 4'b1000, 4'b0111};
  logic [3:0] s_b [5] = '{4'b0000, 4'b1111, 4'b0111, 4'b1000, 4'b0110};
  logic [2:0] s_e [5] = '{CMP_LT, CMP_GT, CMP_LT, CMP_EQ, CMP_GT};

  initial begin
    logic [2:0] exp;
    int ra, rb;
    bit rs;

    rst_n = 1'b0;
    drive4(1'b0, 4'b0101, 4'b0011);
    v7 = 1'b1; s7 = 1'b0; a7 = 7'd9;  b7 = 7'd3;
    v1 = 1'b1; s1 = 1'b0; a1 = 1'b1;  b1 = 1'b0;

    // Reset held two cycles with valid input present
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst4", {ov4, gt4, lt4, eq4}, {1'b0, CMP_NONE});
      chk("rst7", {ov7, gt7, lt7, eq7}, {1'b0, CMP_NONE});
      chk("rst1", {ov1, gt1, lt1, eq1}, {1'b0, CMP_NONE});
    end
    rst_n = 1'b1;
    chk("rel4", {ov4, gt4, lt4, eq4}, {1'b0, CMP_NONE});
    v7 = 1'b0; v1 = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive4(1'b0, u_a[i], u_b[i]);
      step();
      chk($sformatf("uns%0d", i), {ov4, gt4, lt4, eq4}, {1'b1, u_e[i]});
    end

    for (int i = 0; i < 5; i++) begin
      drive4(1'b1, s_a[i], s_b[i]);
      step();
      chk($sformatf("sgn%0d", i), {ov4, gt4, lt4, eq4}, {1'b1, s_e[i]});
    end

    // Flags hold when in_valid drops
    drive4(1'b0, 4'b0110, 4'b0011);
    step();
    chk("gate_v", {ov4, gt4, lt4, eq4}, {1'b1, CMP_GT});
    v4 = 1'b0; a4 = 4'b0000; b4 = 4'b1111;
    step();
    chk("gate_h", {ov4, gt4, lt4, eq4}, {1'b0, CMP_GT});
    step();
    chk("gate_h2", {ov4, gt4, lt4, eq4}, {1'b0, CMP_GT});

    // Mid-stream reset discards the sample presented alongside it
    drive4(1'b0, 4'd1, 4'd2);
    step();
    chk("mid_pre", {ov4, gt4, lt4, eq4}, {1'b1, CMP_LT});
    rst_n = 1'b0;
    drive4(1'b0, 4'd5, 4'd3);
    step();
    chk("mid_rst", {ov4, gt4, lt4, eq4}, {1'b0, CMP_NONE});
    rst_n = 1'b1;
    drive4(1'b0, 4'd9, 4'd9);
    step();
    chk("mid_post", {ov4, gt4, lt4, eq4}, {1'b1, CMP_EQ});

    // N=1: signed treats 1 as -1
    v1 = 1'b1; s1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    step();
    chk("n1_sgn", {ov1, gt1, lt1, eq1}, {1'b1, CMP_GT});
    s1 = 1'b0;
    step();
    chk("n1_uns", {ov1, gt1, lt1, eq1}, {1'b1, CMP_LT});
    a1 = 1'b1;
    step();
    chk("n1_eq", {ov1, gt1, lt1, eq1}, {1'b1, CMP_EQ});
    v1 = 1'b0;

    // Exhaustive N=4 in both modes, random N=7 alongside
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          drive4(m[0], a[3:0], b[3:0]);
          ra = int'($urandom_range(0, 127));
          rb = ($urandom_range(0, 7) == 0) ? ra : int'($urandom_range(0, 127));
          rs = 1'($urandom_range(0, 1));
          v7 = 1'b1; s7 = rs; a7 = ra[6:0]; b7 = rb[6:0];
          step();
          exp = ref_cmp(a, b, 4, m[0]);
          chk($sformatf("sw4 m%0d %0d/%0d", m, a, b), {ov4, gt4, lt4, eq4}, {1'b1, exp});
          chk("oh4", 32'($countones({gt4, lt4, eq4})), 32'd1);
          exp = ref_cmp(ra, rb, 7, rs);
          chk($sformatf("sw7 s%0d %0d/%0d", rs, ra, rb), {ov7, gt7, lt7, eq7}, {1'b1, exp});
          chk("oh7", 32'($countones({gt7, lt7, eq7})), 32'd1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nbit_comparator.md
Name: nbit_comparator

Overview:
- Registered N-bit magnitude comparator: compares operands A and B and produces mutually exclusive greater/less/equal flags.
- Supports unsigned and two's-complement signed compare, selected per sample.
- Sits in datapath control logic wherever a registered, one-cycle-latency relational result with a valid qualifier is needed.

Parameters:
- N, 4, operand width in bits; legal range N >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  A/B/cmp_signed are valid this cycle
- cmp_signed  input  1  1 = two's-complement compare, 0 = unsigned compare
- A  input  N  operand A
- B  input  N  operand B
- out_valid  output  1  result flags are valid this cycle
- A_gt_B  output  1  A > B
- A_lt_B  output  1  A < B
- A_eq_B  output  1  A == B

Behaviour:
- One clock domain. Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk.
- Reset values: out_valid=0, A_gt_B=0, A_lt_B=0, A_eq_B=0.
- Latency is exactly 1 cycle.
  - If in_valid=1 at edge k, then at edge k+1 out_valid=1 and the flags reflect A/B/cmp_signed sampled at edge k.
- If in_valid=0 at an edge:
  - out_valid is 0 the next cycle.
  - Flags hold their previous values; they are not cleared.
- Back-to-back samples are accepted every cycle with no stall and no backpressure.
- When out_valid=1, exactly one of A_gt_B, A_lt_B, A_eq_B is 1. The flags are all 0 only after reset, before the first valid sample.
- Unsigned mode (cmp_signed=0): A and B are treated as unsigned 0..2^N-1.
- Signed mode (cmp_signed=1): A and B are treated as two's complement -2^(N-1)..2^(N-1)-1.
  - When MSBs differ, the operand with MSB=0 is greater.
  - Otherwise the lower N-1 bits are compared unsigned.
- Equality is mode-independent: bitwise identical means A_eq_B=1.
- Compare structure: MSB-first priority.
  - Each bit position produces (gt_i, eq_i).
  - Results merge in a log2 tree: gt = gt_hi | (eq_hi & gt_lo); eq = eq_hi & eq_lo.
  - lt is derived as ~gt & ~eq.
  - For N not a power of two, pad missing leaves with eq=1, gt=0.
- N=1: signed mode treats 1 as -1, so 0 > 1 in signed mode.
- Reset asserted mid-stream: the next edge forces reset values. A sample presented in the same cycle as rst_n=0 is discarded and does not appear on the outputs.
- No internal state besides the output registers; no X propagation from an undriven in_valid=0 operand into out_valid.

Decomposition:
- Shared package nbit_cmp_pkg:
  - typedef cmp_result_t {gt, eq} used by the tree nodes.
  - Constant encodings CMP_GT, CMP_LT, CMP_EQ for bench scoreboards.
- One sub-module: nbit_cmp_merge, a combinational merge of two cmp_result_t (high, low) into one cmp_result_t.
  - Instantiated in a generate tree of depth ceil(log2 N).
- The top level holds the bit-slice generation, signed MSB fix-up, tree instantiation and output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0 and all flags 0 throughout; first release cycle still out_valid=0.
- Unsigned directed, N=4, cmp_signed=0, one sample per cycle:
  - 0101/0101 -> EQ
  - 0110/0011 -> GT
  - 0010/0111 -> LT
  - 1111/0000 -> GT
  - 0000/1111 -> LT
  - Each appears one cycle later with out_valid=1.
- Signed directed, N=4, cmp_signed=1:
  - 1111/0000 -> LT (-1<0)
  - 0000/1111 -> GT
  - 1000/0111 -> LT (-8<7)
  - 1000/1000 -> EQ
  - 0111/0110 -> GT
- Valid gating: valid sample 0110/0011 (GT), then in_valid=0 with A/B changed to 0000/1111 -> out_valid drops to 0 and flags stay GT.
- Mid-stream reset: continuous valid stream, pull rst_n=0 for one cycle -> next cycle outputs are reset values; the stream resumes with correct 1-cycle latency after release.
- Random sweep, N=4 (exhaustive 256 pairs x 2 modes) and N=7: compare against a reference model; check one-hot flags whenever out_valid=1.
